reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 22 ++
 rtl/reg_wb_arbiter.sv | 100 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared constants and grant encoding for the writeback arbiter
//
// Purpose: default widths, the hard-wired zero register address, and the
//          two-way grant encoding used by reg_wb_arbiter and rr_arb2.
// Ports:   none (package)
package reg_wb_pkg;

  localparam int REG_WIDTH     = 32;  // default data width of one register
  localparam int REG_WIDTH_ADD = 5;   // default register address width
  localparam int REG_ZERO      = 0;   // register 0 reads as zero, never written

  // Identity of the requester that won the most recent transfer.
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant logic
//
// Purpose: one-hot grant for two requesters; a lone requester always wins,
//          a tie goes to the requester that did not win last time.
// Ports:   req[1:0]   in   request lines (bit 0 = A, bit 1 = B)
//          last_grant in   requester granted on the most recent transfer
//          gnt[1:0]   out  one-hot (or zero) grant, same bit order as req
module rr_arb2
  import reg_wb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | (last_grant == GRANT_B));
    gnt[1] = req[1] & (~req[0] | (last_grant == GRANT_A));
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file writeback arbiter with hazard stall
//
// Purpose: merges ALU (A) and load (B) writeback requests onto the single
//          register-file write port, flags decode-stage RAW hazards and
//          counts contended cycles.
// Ports:   clk, reset                 clock, synchronous active-high reset
//          a_valid/a_addr/a_data      requester A write request
//          a_ready                    requester A accepted this cycle
//          b_valid/b_addr/b_data      requester B write request
//          b_ready                    requester B accepted this cycle
//          rd_addr1, rd_addr2         decode-stage source register addresses
//          stall                      a source register has a write outstanding
//          we_out/waddr_out/wdata_out registered register-file write port
//          conflict_cnt               saturating count of contended cycles
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter int WIDTH_ADD = REG_WIDTH_ADD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  input  logic [WIDTH_ADD-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [WIDTH_ADD-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_data,
  output logic                 b_ready,
  input  logic [WIDTH_ADD-1:0] rd_addr1,
  input  logic [WIDTH_ADD-1:0] rd_addr2,
  output logic                 stall,
  output logic                 we_out,
  output logic [WIDTH_ADD-1:0] waddr_out,
  output logic [WIDTH-1:0]     wdata_out,
  output logic [15:0]          conflict_cnt
);

  localparam logic [WIDTH_ADD-1:0] ZERO_ADDR = WIDTH_ADD'(REG_ZERO);

  grant_t               last_grant;
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic                 xfer;
  logic [WIDTH_ADD-1:0] sel_addr;
  logic [WIDTH-1:0]     sel_data;

  // Masking requests during reset keeps ready low without a separate gate.
  assign req = reset ? 2'b00 : {b_valid, a_valid};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign xfer     = gnt[0] | gnt[1];
  assign sel_addr = gnt[1] ? b_addr : a_addr;
  assign sel_data = gnt[1] ? b_data : a_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_out       <= 1'b0;
      waddr_out    <= '0;
      wdata_out    <= '0;
      conflict_cnt <= 16'h0000;
      last_grant   <= GRANT_B;
    end else begin
      // Writes to register 0 are accepted from the requester but dropped here.
      we_out <= xfer && (sel_addr != ZERO_ADDR);
      if (xfer) begin
        waddr_out  <= sel_addr;
        wdata_out  <= sel_data;
        last_grant <= gnt[1] ? GRANT_B : GRANT_A;
      end
      if (a_valid && b_valid && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'h0001;
      end
    end
  end

  // A source register is hazardous while either requester holds a pending
  // write to it or the write port is committing it this cycle.
  logic hz1, hz2;
  always_comb begin
    hz1 = (rd_addr1 != ZERO_ADDR) &&
          ((a_valid && (rd_addr1 == a_addr)) ||
           (b_valid && (rd_addr1 == b_addr)) ||
           (we_out  && (rd_addr1 == waddr_out)));
    hz2 = (rd_addr2 != ZERO_ADDR) &&
          ((a_valid && (rd_addr2 == a_addr)) ||
           (b_valid && (rd_addr2 == b_addr)) ||
           (we_out  && (rd_addr2 == waddr_out)));
    stall = hz1 | hz2;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr, rd_addr1, rd_addr2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, stall, we_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .stall        (stall),
    .we_out       (we_out),
    .waddr_out    (waddr_out),
    .wdata_out    (wdata_out),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    tick(); tick();

    // ready held low during reset even with both requesting
    a_valid = 1'b1; b_valid = 1'b1; #1;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("rst_we", 32'(we_out), 32'd0);
    check("rst_waddr", 32'(waddr_out), 32'd0);
    check("rst_wdata", wdata_out, 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; #1;

    // lone A request, latency-1 write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF; #1;
    check("soloA_a_ready", 32'(a_ready), 32'd1);
    check("soloA_b_ready", 32'(b_ready), 32'd0);
    check("soloA_stall", 32'(stall), 32'd0);
    tick();
    a_valid = 1'b0;
    check("soloA_we", 32'(we_out), 32'd1);
    check("soloA_waddr", 32'(waddr_out), 32'd5);
    check("soloA_wdata", wdata_out, 32'hDEADBEEF);
    tick();
    check("idle_we", 32'(we_out), 32'd0);
    check("idle_waddr_hold", 32'(waddr_out), 32'd5);
    check("idle_wdata_hold", wdata_out, 32'hDEADBEEF);

    // contention round robin A,B,A,B from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_addr = 5'(i + 1);  a_data = 32'hA0 + 32'(i);
      b_addr = 5'(i + 10); b_data = 32'hB0 + 32'(i);
      #1;
      check("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_we", 32'(we_out), 32'd1);
      check("rr_waddr", 32'(waddr_out), (i % 2 == 0) ? 32'(i + 1) : 32'(i + 10));
      check("rr_wdata", wdata_out, (i % 2 == 0) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i));
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("rr_cnt", 32'(conflict_cnt), 32'd4);

    // same target address: A first (last grant was B), B's value lands last
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd3; b_addr = 5'd3;
    a_data = 32'h111; b_data = 32'h222; #1;
    check("same_a_first", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0; #1;
    check("same_wdata1", wdata_out, 32'h111);
    check("same_b_second", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("same_we2", 32'(we_out), 32'd1);
    check("same_waddr2", 32'(waddr_out), 32'd3);
    check("same_wdata2", wdata_out, 32'h222);
    check("same_cnt", 32'(conflict_cnt), 32'd5);

    // write to register 0 accepted but suppressed
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1; #1;
    check("zero_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("zero_we", 32'(we_out), 32'd0);

    // stall on pending and committing writes
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77; rd_addr1 = 5'd7; #1;
    check("stall_pending", 32'(stall), 32'd1);
    tick();
    a_valid = 1'b0; #1;
    check("stall_commit_we", 32'(we_out), 32'd1);
    check("stall_commit", 32'(stall), 32'd1);
    tick();
    check("stall_idle", 32'(stall), 32'd0);
    rd_addr1 = 5'd0;
    b_valid = 1'b1; b_addr = 5'd12; rd_addr2 = 5'd12; #1;
    check("stall_b_rd2", 32'(stall), 32'd1);
    tick();
    b_valid = 1'b0; a_valid = 1'b1; a_addr = 5'd0; rd_addr2 = 5'd0; #1;
    check("stall_zero_src", 32'(stall), 32'd0);
    tick();
    a_valid = 1'b0;
    check("stall_zero_we", 32'(we_out), 32'd0);

    // reset right after an accepted transfer discards the pending write
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99; #1;
    check("mid_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("mid_we_before", 32'(we_out), 32'd1);
    reset = 1'b1; b_valid = 1'b1; #1;
    check("mid_rst_a_ready", 32'(a_ready), 32'd0);
    check("mid_rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("mid_we_after", 32'(we_out), 32'd0);
    check("mid_cnt", 32'(conflict_cnt), 32'd0);
    reset = 1'b0; #1;
    check("post_rst_a_wins", 32'(a_ready), 32'd1);
    check("post_rst_b_waits", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("post_rst_waddr", 32'(waddr_out), 32'd9);

    // conflict counter saturation
    reset = 1'b1; tick(); reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(conflict_cnt), 32'h0000FFFE);
    tick();
    check("sat_ffff", 32'(conflict_cnt), 32'h0000FFFF);
    repeat (4465) @(posedge clk);
    #1;
    check("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);
    a_valid = 1'b0; b_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
